// File: rtl/waveguide_arbiter.sv
// Round-robin owner of the shared optical waveguide: one-cycle grant pulse, then a
// reserved transmit window plus guard gap, with a sticky illegal-launch monitor.
module waveguide_arbiter #(
  parameter int unsigned NUM_ROUTERS  = 4,
  parameter int unsigned TX_CYCLES    = 1,
  parameter int unsigned GUARD_CYCLES = 1,
  localparam int unsigned IDW = $clog2(NUM_ROUTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_ROUTERS-1:0] request_to_send,
  input  logic [NUM_ROUTERS-1:0] mod_valid_in,
  output logic [NUM_ROUTERS-1:0] permission_granted_send,
  output logic [IDW-1:0]         grant_id,
  output logic                   waveguide_busy,
  output logic                   collision_err,
  output logic [31:0]            grant_count
);

  localparam int unsigned CNT_MAX = (TX_CYCLES > GUARD_CYCLES) ? TX_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNTW    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNTW-1:0] TX_LOAD    = CNTW'(TX_CYCLES - 1);
  localparam logic [CNTW-1:0] GUARD_LOAD = CNTW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_GUARD = 2'd3
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [IDW-1:0]  last_id;

  logic            win_valid_c;
  logic [IDW-1:0]  win_id_c;
  logic            arb_point_c;
  logic            collision_c;
  logic [NUM_ROUTERS-1:0] owner_mask_c;

  // Search from last_id+1 upward with wrap; walking the distance downward lets the
  // closest requester overwrite farther ones.
  always_comb begin
    win_valid_c = 1'b0;
    win_id_c    = '0;
    for (int unsigned k = NUM_ROUTERS; k >= 1; k--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((32'(last_id) + k) % NUM_ROUTERS);
      if (request_to_send[idx]) begin
        win_valid_c = 1'b1;
        win_id_c    = idx;
      end
    end
  end

  // The final edge of a window doubles as the idle decision point, so back-to-back
  // grants land exactly 1+TX_CYCLES+GUARD_CYCLES cycles apart.
  always_comb begin
    arb_point_c = (state == S_IDLE)
               || (state == S_BUSY  && cnt == '0 && GUARD_CYCLES == 0)
               || (state == S_GUARD && cnt == '0);
  end

  // Illegal launch: several modulators at once, any launch outside BUSY, or a
  // non-owner launching during BUSY.
  always_comb begin
    owner_mask_c = NUM_ROUTERS'(1) << grant_id;
    collision_c  = ($countones(mod_valid_in) > 1)
                || ((|mod_valid_in) && state != S_BUSY)
                || (state == S_BUSY && |(mod_valid_in & ~owner_mask_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= S_IDLE;
      cnt                     <= '0;
      last_id                 <= IDW'(NUM_ROUTERS - 1);
      permission_granted_send <= '0;
      grant_id                <= '0;
      waveguide_busy          <= 1'b0;
      collision_err           <= 1'b0;
      grant_count             <= '0;
    end else begin
      permission_granted_send <= '0;
      collision_err           <= collision_err | collision_c;
      if (arb_point_c) begin
        if (enable && win_valid_c) begin
          state                   <= S_GRANT;
          grant_id                <= win_id_c;
          last_id                 <= win_id_c;
          grant_count             <= grant_count + 32'd1;
          permission_granted_send <= NUM_ROUTERS'(1) << win_id_c;
          waveguide_busy          <= 1'b1;
        end else begin
          state          <= S_IDLE;
          waveguide_busy <= 1'b0;
        end
      end else begin
        case (state)
          S_GRANT: begin
            state <= S_BUSY;
            cnt   <= TX_LOAD;
          end
          S_BUSY: begin
            if (cnt == '0) begin
              state <= S_GUARD;
              cnt   <= GUARD_LOAD;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          S_GUARD: cnt <= cnt - CNTW'(1);
          default: begin
            state          <= S_IDLE;
            waveguide_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_waveguide_arbiter.sv
// Directed bench for waveguide_arbiter: default instance plus a TX_CYCLES=3,
// GUARD_CYCLES=0 instance; expected grant owners are queued and popped per pulse.
module tb_waveguide_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, en1;
  logic [3:0] req0, req1, mv0, mv1;
  logic [3:0] pgs0, pgs1;
  logic [1:0] gid0, gid1;
  logic       busy0, busy1, coll0, coll1;
  logic [31:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int sb0[$];
  int sb1[$];

  waveguide_arbiter u_def (
    .clk(clk), .rst_n(rst_n), .enable(en0), .request_to_send(req0),
    .mod_valid_in(mv0), .permission_granted_send(pgs0), .grant_id(gid0),
    .waveguide_busy(busy0), .collision_err(coll0), .grant_count(cnt0)
  );

  waveguide_arbiter #(.NUM_ROUTERS(4), .TX_CYCLES(3), .GUARD_CYCLES(0)) u_tx3 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .request_to_send(req1),
    .mod_valid_in(mv1), .permission_granted_send(pgs1), .grant_id(gid1),
    .waveguide_busy(busy1), .collision_err(coll1), .grant_count(cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until a grant pulse appears (bounded), then compare it with the queued owner.
  task automatic wait_grant(input bit sel, input string tag, output int n);
    logic [3:0] p;
    logic [3:0] ep;
    int e;
    n = 0;
    do begin
      step();
      n++;
      p = sel ? pgs1 : pgs0;
    end while (p === 4'b0 && n < 40);
    e = 0;
    if (sel && sb1.size() > 0) e = sb1.pop_front();
    else if (!sel && sb0.size() > 0) e = sb0.pop_front();
    ep = 4'(1) << e;
    chk({tag, "_pulse"}, 64'(p), 64'(ep));
    chk({tag, "_id"}, 64'(sel ? gid1 : gid0), 64'(e));
  endtask

  initial begin
    int n;
    logic [3:0] g;
    rst_n = 1'b0;
    en0 = 1'b1; req0 = '0; mv0 = '0;
    en1 = 1'b0; req1 = '0; mv1 = '0;
    repeat (3) step();
    chk("rst_pgs",   64'(pgs0),  64'd0);
    chk("rst_gid",   64'(gid0),  64'd0);
    chk("rst_busy",  64'(busy0), 64'd0);
    chk("rst_coll",  64'(coll0), 64'd0);
    chk("rst_count", 64'(cnt0),  64'd0);

    // Single request from router 2
    rst_n = 1'b1;
    step(); step();
    req0 = 4'b0100;
    sb0.push_back(2);
    wait_grant(1'b0, "single", n);
    chk("single_latency", 64'(n), 64'd1);
    chk("single_count", 64'(cnt0), 64'd1);
    chk("single_busy0", 64'(busy0), 64'd1);
    req0 = '0;
    step();
    chk("single_pulse_width", 64'(pgs0), 64'd0);
    chk("single_busy1", 64'(busy0), 64'd1);
    step();
    chk("single_busy2", 64'(busy0), 64'd1);
    step();
    chk("single_busy_end", 64'(busy0), 64'd0);

    // Full contention from reset: 0,1,2,3,0 at 3-cycle spacing, routers launch in BUSY
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 4'hF;
    for (int i = 0; i < 5; i++) sb0.push_back(i % 4);
    for (int i = 0; i < 5; i++) begin
      wait_grant(1'b0, "rr", n);
      if (i > 0) chk("rr_spacing", 64'(n), 64'd1);
      g = pgs0;
      step();
      mv0 = g;
      step();
      mv0 = '0;
    end
    req0 = '0;
    chk("rr_count", 64'(cnt0), 64'd5);
    chk("rr_no_collision", 64'(coll0), 64'd0);
    step();
    chk("rr_idle", 64'(busy0), 64'd0);

    // Wrap and skip: park last_id at 3, then requests 0b1010 -> 1,3,1
    req0 = 4'b1000;
    sb0.push_back(3);
    wait_grant(1'b0, "park3", n);
    req0 = 4'b1010;
    sb0.push_back(1); sb0.push_back(3); sb0.push_back(1);
    for (int i = 0; i < 3; i++) begin
      wait_grant(1'b0, "wrap", n);
      chk("wrap_spacing", 64'(n), 64'd3);
    end
    req0 = '0;

    // Non-owner launches alongside owner 1 during BUSY
    step();
    mv0 = 4'b0011;
    step();
    chk("coll_busy_set", 64'(coll0), 64'd1);
    mv0 = '0;
    step(); step();
    chk("coll_sticky", 64'(coll0), 64'd1);
    chk("coll_idle_after", 64'(busy0), 64'd0);

    // Launch while IDLE
    rst_n = 1'b0;
    #1;
    chk("coll_async_clear", 64'(coll0), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    mv0 = 4'b0001;
    step();
    chk("coll_idle_set", 64'(coll0), 64'd1);
    mv0 = '0;

    // Reset in the middle of a BUSY window
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0 = 4'b0100;
    sb0.push_back(2);
    wait_grant(1'b0, "mid", n);
    req0 = '0;
    step();
    chk("mid_pre_busy", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("mid_busy_clr",  64'(busy0), 64'd0);
    chk("mid_gid_clr",   64'(gid0),  64'd0);
    chk("mid_count_clr", 64'(cnt0),  64'd0);
    chk("mid_pgs_clr",   64'(pgs0),  64'd0);
    req0 = 4'b0110;
    sb0.push_back(1);
    #2;
    rst_n = 1'b1;
    wait_grant(1'b0, "post_rst", n);
    chk("post_rst_count", 64'(cnt0), 64'd1);
    req0 = '0;
    repeat (4) step();

    // TX_CYCLES=3, GUARD_CYCLES=0 instance: enable gating and 4-cycle spacing
    req1 = 4'b0001;
    repeat (4) step();
    chk("en_off_busy",  64'(busy1), 64'd0);
    chk("en_off_count", 64'(cnt1),  64'd0);
    en1 = 1'b1;
    sb1.push_back(0); sb1.push_back(0);
    wait_grant(1'b1, "en_on", n);
    chk("en_on_latency", 64'(n), 64'd1);
    wait_grant(1'b1, "tx3", n);
    chk("tx3_spacing", 64'(n), 64'd4);
    req1 = '0;
    step();
    chk("tx3_busy1", 64'(busy1), 64'd1);
    step();
    chk("tx3_busy2", 64'(busy1), 64'd1);
    step();
    chk("tx3_busy3", 64'(busy1), 64'd1);
    step();
    chk("tx3_idle", 64'(busy1), 64'd0);
    chk("tx3_count", 64'(cnt1), 64'd2);
    chk("tx3_no_collision", 64'(coll1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
